// File: rtl/sspwm_seq_if.sv
// sspwm_seq_if: run request / amplitude target in, counter, compare value,
// polarity and FSM state out, grouped for the sine PWM sequencer.
interface sspwm_seq_if;
    logic        en;
    logic [7:0]  amp_target;
    logic [11:0] cnt;
    logic        period_tick;
    logic [11:0] duty;
    logic        polarity;
    logic [1:0]  state;

    modport master (
        output en,
        output amp_target,
        input  cnt,
        input  period_tick,
        input  duty,
        input  polarity,
        input  state
    );

    modport slave (
        input  en,
        input  amp_target,
        output cnt,
        output period_tick,
        output duty,
        output polarity,
        output state
    );
endinterface

// File: rtl/sspwm_seq.sv
// sspwm_seq: PWM period counter, half-wave sine stepping and amplitude ramp.
// Define SSPWM_SEQ_MINPULSE_EN to clamp duty away from 0 and PERIOD_TOP.
module sspwm_seq #(
    parameter int PERIOD_TOP = 3906,
    parameter int LUT_AW     = 6,
    parameter int RAMP_STEP  = 16,
    parameter int MIN_PULSE  = 20
) (
    input  logic       clk,
    input  logic       rst,
    sspwm_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

`ifdef SSPWM_SEQ_MINPULSE_EN
    localparam bit MP_EN = 1'b1;
`else
    localparam bit MP_EN = 1'b0;
`endif

    localparam logic [11:0] PT12  = 12'(PERIOD_TOP);
    localparam logic [11:0] MP12  = 12'(MIN_PULSE);
    localparam logic [11:0] HI12  = 12'(PERIOD_TOP - MIN_PULSE);
    localparam logic [7:0]  STEP8 = 8'(RAMP_STEP);
    localparam logic [LUT_AW-1:0] IDX_MAX  = '1;
    localparam logic [LUT_AW-1:0] IDX_HALF = {1'b1, {(LUT_AW-1){1'b0}}};

    logic [11:0]       r_cnt;
    logic              r_tick;
    logic [LUT_AW-1:0] r_idx;
    logic [7:0]        r_amp;
    state_t            r_state;
    logic [11:0]       r_duty;
    logic              r_pol;

    logic              w_wrap;
    logic [LUT_AW-1:0] w_idx_next;
    logic [LUT_AW-1:0] w_fold;
    logic [7:0]        w_amp_ramp;
    logic [7:0]        w_amp_dn;
    logic [7:0]        w_amp_next;
    logic [11:0]       w_lut;
    logic [19:0]       w_prod;
    logic [11:0]       w_raw;
    logic [11:0]       w_duty;

    // Table entries are round(3906*sin); rescaled if PERIOD_TOP differs.
    function automatic logic [11:0] f_sc(input int t);
        return 12'((t * PERIOD_TOP + 1953) / 3906);
    endfunction

    assign w_wrap     = (r_state != S_IDLE) && (r_idx == IDX_MAX);
    assign w_idx_next = (r_state == S_IDLE) ? '0 : r_idx + LUT_AW'(1);
    // Second quarter mirrors the first: lut[N-i] == lut[i].
    assign w_fold     = (w_idx_next[LUT_AW-1] && w_idx_next != IDX_HALF)
                      ? -w_idx_next : w_idx_next;
    assign w_amp_dn   = (r_amp > STEP8) ? r_amp - STEP8 : '0;

    // One ramp step toward the target, landing exactly on it when close.
    always_comb begin
        w_amp_ramp = bus.amp_target;
        if (r_amp < bus.amp_target && (bus.amp_target - r_amp) > STEP8)
            w_amp_ramp = r_amp + STEP8;
        else if (r_amp > bus.amp_target && (r_amp - bus.amp_target) > STEP8)
            w_amp_ramp = r_amp - STEP8;
    end

    // Amplitude after this tick, stepped only on wraps by current-state rules.
    always_comb begin
        w_amp_next = r_amp;
        case (r_state)
            S_IDLE:  w_amp_next = '0;
            S_RAMP:  w_amp_next = w_wrap ? w_amp_ramp : r_amp;
            S_STOP:  w_amp_next = w_wrap ? w_amp_dn : r_amp;
            default: w_amp_next = r_amp;
        endcase
    end

    // Quarter-wave sine table addressed by the folded next index.
    always_comb begin
        w_lut = '0;
        case (w_fold)
            6'd0:    w_lut = f_sc(0);
            6'd1:    w_lut = f_sc(192);
            6'd2:    w_lut = f_sc(383);
            6'd3:    w_lut = f_sc(573);
            6'd4:    w_lut = f_sc(762);
            6'd5:    w_lut = f_sc(949);
            6'd6:    w_lut = f_sc(1134);
            6'd7:    w_lut = f_sc(1316);
            6'd8:    w_lut = f_sc(1495);
            6'd9:    w_lut = f_sc(1670);
            6'd10:   w_lut = f_sc(1841);
            6'd11:   w_lut = f_sc(2008);
            6'd12:   w_lut = f_sc(2170);
            6'd13:   w_lut = f_sc(2327);
            6'd14:   w_lut = f_sc(2478);
            6'd15:   w_lut = f_sc(2623);
            6'd16:   w_lut = f_sc(2762);
            6'd17:   w_lut = f_sc(2894);
            6'd18:   w_lut = f_sc(3019);
            6'd19:   w_lut = f_sc(3137);
            6'd20:   w_lut = f_sc(3248);
            6'd21:   w_lut = f_sc(3350);
            6'd22:   w_lut = f_sc(3445);
            6'd23:   w_lut = f_sc(3531);
            6'd24:   w_lut = f_sc(3609);
            6'd25:   w_lut = f_sc(3678);
            6'd26:   w_lut = f_sc(3738);
            6'd27:   w_lut = f_sc(3789);
            6'd28:   w_lut = f_sc(3831);
            6'd29:   w_lut = f_sc(3864);
            6'd30:   w_lut = f_sc(3887);
            6'd31:   w_lut = f_sc(3901);
            6'd32:   w_lut = f_sc(3906);
            default: w_lut = '0;
        endcase
    end

    assign w_prod = {8'd0, w_lut} * {12'd0, w_amp_next};
    assign w_raw  = 12'(w_prod >> 8);

    // Optional clamp keeps pulses away from unusably narrow widths.
    always_comb begin
        w_duty = w_raw;
        if (MP_EN) begin
            if (w_raw != 12'd0 && w_raw < MP12)
                w_duty = '0;
            else if (w_raw > HI12)
                w_duty = PT12;
        end
    end

    // Free-running period counter; tick is high while cnt sits at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == PT12) ? '0 : r_cnt + 12'd1;
            r_tick <= (r_cnt == PT12 - 12'd1);
        end
    end

    // Soft-start/soft-stop FSM with its datapath, advanced once per period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_amp   <= '0;
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_pol   <= 1'b0;
        end else if (r_tick) begin
            r_idx  <= w_idx_next;
            r_amp  <= w_amp_next;
            r_duty <= w_duty;
            r_pol  <= w_wrap ? ~r_pol : r_pol;
            case (r_state)
                S_IDLE: begin
                    r_idx  <= '0;
                    r_amp  <= '0;
                    r_duty <= '0;
                    r_pol  <= 1'b0;
                    if (bus.en)
                        r_state <= S_RAMP;
                end
                S_RAMP: begin
                    if (!bus.en)
                        r_state <= S_STOP;
                    else if (w_amp_next == bus.amp_target)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!bus.en)
                        r_state <= S_STOP;
                    else if (bus.amp_target != r_amp)
                        r_state <= S_RAMP;
                end
                S_STOP: begin
                    if (w_wrap && w_amp_next == 8'd0) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_duty  <= '0;
                        r_pol   <= 1'b0;
                    end else if (bus.en) begin
                        r_state <= S_RAMP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cnt         = r_cnt;
    assign bus.period_tick = r_tick;
    assign bus.duty        = r_duty;
    assign bus.polarity    = r_pol;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_sspwm_seq.sv
// tb_sspwm_seq: directed checks of sspwm_seq with a short PWM period.
// Expected values are hand-derived from the sine table and ramp rules.
module tb_sspwm_seq;
    localparam int PT = 15;
    localparam int MP = 3;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   ep;
    int   a;
    int   n;

    sspwm_seq_if bus ();

    sspwm_seq #(
        .PERIOD_TOP(PT),
        .LUT_AW(6),
        .RAMP_STEP(16),
        .MIN_PULSE(MP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int edut(input int raw);
`ifdef SSPWM_SEQ_MINPULSE_EN
        if (raw > 0 && raw < MP)
            return 0;
        if (raw > PT - MP)
            return PT;
`endif
        return raw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic tick1();
        int g = 0;
        while (bus.period_tick !== 1'b1 && g < PT + 3) begin
            @(negedge clk);
            g++;
        end
        chk("tick_seen", 32'(bus.period_tick), 32'd1);
        @(negedge clk);
    endtask

    task automatic adv(input int cnt_ticks);
        for (int i = 0; i < cnt_ticks; i++)
            tick1();
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.amp_target = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_cnt",   32'(bus.cnt), 32'd0);
        chk("rst_tick",  32'(bus.period_tick), 32'd0);
        chk("rst_duty",  32'(bus.duty), 32'd0);
        chk("rst_pol",   32'(bus.polarity), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);

        bus.en = 1'b1;
        bus.amp_target = 8'd255;
        rst = 1'b0;
        n = 0;
        while (bus.period_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick_n", n, PT);
        chk("first_tick_cnt", 32'(bus.cnt), PT);

        tick1();
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_duty", 32'(bus.duty), 32'd0);
        chk("tick_pulse", 32'(bus.period_tick), 32'd0);

        // Soft start: amp 0,16,..,240 then saturates to 255.
        ep = 0;
        for (int k = 0; k < 16; k++) begin
            a = 16 * k;
            adv(32);
            chk($sformatf("ramp_peak%0d", k), 32'(bus.duty),
                edut((PT * a) >> 8));
            chk($sformatf("ramp_st%0d", k), 32'(bus.state), 32'd1);
            adv(32);
            ep ^= 1;
            chk($sformatf("ramp_pol%0d", k), 32'(bus.polarity), ep);
            chk($sformatf("ramp_wst%0d", k), 32'(bus.state),
                (k == 15) ? 32'd2 : 32'd1);
            chk($sformatf("ramp_wduty%0d", k), 32'(bus.duty), 32'd0);
        end

        // RUN at amp 255: lut[4]=3, lut[16]=11, lut[32]=15.
        adv(4);
        chk("run_idx4", 32'(bus.duty), edut((3 * 255) >> 8));
        adv(12);
        chk("run_idx16", 32'(bus.duty), edut((11 * 255) >> 8));
        adv(16);
        chk("run_idx32", 32'(bus.duty), edut((15 * 255) >> 8));
        adv(32);
        ep ^= 1;
        chk("run_pol", 32'(bus.polarity), ep);
        chk("run_state", 32'(bus.state), 32'd2);
        chk("run_duty0", 32'(bus.duty), 32'd0);
        chk("run_cnt0", 32'(bus.cnt), 32'd0);

        // Soft stop down to 127, then re-enable.
        bus.en = 1'b0;
        adv(1);
        chk("stop_state", 32'(bus.state), 32'd3);
        for (int m = 1; m <= 8; m++) begin
            a = 255 - 16 * (m - 1);
            adv((m == 1) ? 31 : 32);
            chk($sformatf("stop_peak%0d", m), 32'(bus.duty),
                edut((PT * a) >> 8));
            adv(32);
            ep ^= 1;
            chk($sformatf("stop_pol%0d", m), 32'(bus.polarity), ep);
            chk($sformatf("stop_st%0d", m), 32'(bus.state), 32'd3);
        end

        bus.en = 1'b1;
        adv(1);
        chk("reramp_state", 32'(bus.state), 32'd1);
        for (int j = 1; j <= 8; j++) begin
            a = 127 + 16 * (j - 1);
            adv((j == 1) ? 31 : 32);
            chk($sformatf("reramp_peak%0d", j), 32'(bus.duty),
                edut((PT * a) >> 8));
            adv(32);
            ep ^= 1;
            chk($sformatf("reramp_pol%0d", j), 32'(bus.polarity), ep);
            chk($sformatf("reramp_st%0d", j), 32'(bus.state),
                (j == 8) ? 32'd2 : 32'd1);
        end

        // Full soft stop: 16 wraps from 255 reach 0 and IDLE.
        bus.en = 1'b0;
        adv(1);
        chk("fstop_state", 32'(bus.state), 32'd3);
        for (int m = 1; m <= 16; m++) begin
            adv((m == 1) ? 63 : 64);
            if (m < 16) begin
                ep ^= 1;
                chk($sformatf("fstop_pol%0d", m), 32'(bus.polarity), ep);
                chk($sformatf("fstop_st%0d", m), 32'(bus.state), 32'd3);
            end else begin
                chk("idle_state", 32'(bus.state), 32'd0);
                chk("idle_pol", 32'(bus.polarity), 32'd0);
                chk("idle_duty", 32'(bus.duty), 32'd0);
            end
        end
        adv(2);
        chk("idle_hold", 32'(bus.state), 32'd0);

        // Asynchronous reset in the middle of a ramp.
        bus.en = 1'b1;
        adv(1);
        chk("ar_state", 32'(bus.state), 32'd1);
        adv(64);
        chk("ar_pol", 32'(bus.polarity), 32'd1);
        n = 0;
        while (bus.cnt !== 12'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_cnt10", 32'(bus.cnt), 32'd10);
        rst = 1'b1;
        #1;
        chk("ar_cnt", 32'(bus.cnt), 32'd0);
        chk("ar_tick", 32'(bus.period_tick), 32'd0);
        chk("ar_duty", 32'(bus.duty), 32'd0);
        chk("ar_polr", 32'(bus.polarity), 32'd0);
        chk("ar_str", 32'(bus.state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bus.period_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_first_n", n, PT);
        chk("ar_first_cnt", 32'(bus.cnt), PT);
        tick1();
        chk("ar_restart", 32'(bus.state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sspwm_seq.md
# sspwm_seq

Sequencer for the sinusoidal PWM stage: owns the PWM period counter, steps through a half-wave sine table once per PWM period, scales each sample by a ramped amplitude, and presents a 12-bit compare value plus polarity to the PWM comparator and H-bridge steering. A soft-start and soft-stop FSM gates the amplitude so the output never jumps between zero and full modulation.

## Interface
- PERIOD_TOP, 3906: terminal count of the PWM period counter. Period is PERIOD_TOP+1 clocks.
- LUT_AW, 6: log2 of samples per half sine cycle. Default is 64 samples.
- RAMP_STEP, 16: amplitude change applied at each half-cycle wrap during ramps.
- MIN_PULSE, 20: minimum pulse width in clocks. Used only when the macro is defined.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request.
- amp_target  in  8  modulation index target. 255 is full scale.
- cnt  out  12  period counter. Reset value 0.
- period_tick  out  1  high in the cycle where cnt==PERIOD_TOP. Reset value 0.
- duty  out  12  compare value for the PWM. Reset value 0.
- polarity  out  1  half-cycle sign. Reset value 0.
- state  out  2  FSM state: IDLE=0, RAMP=1, RUN=2, STOP=3. Reset value 0.

## Operation
- cnt counts 0..PERIOD_TOP and wraps to 0. It runs in every state.
- All updates to idx, amp, state, duty and polarity occur only on the edge where period_tick=1.
- idx counts 0..2^LUT_AW-1 and advances on each tick in RAMP, RUN and STOP.
  - The tick where idx==2^LUT_AW-1 is a "wrap": idx goes to 0 and polarity toggles.
- LUT contents: lut[i] = round(PERIOD_TOP*sin(pi*i/2^LUT_AW)). Implement as an elaborated constant case.
- duty is loaded on each tick with (lut[idx_next]*amp_next)>>8.
  - The product is 20 bits; keep the upper 12 bits.
  - The result is always ≤ PERIOD_TOP.
- FSM, evaluated on ticks only:
  - IDLE: amp=0, idx=0, polarity=0, duty=0. If en=1, go to RAMP.
  - RAMP: at each wrap, amp moves toward amp_target by RAMP_STEP, saturating at amp_target in either direction. When amp_next==amp_target, go to RUN. If en=0, go to STOP.
  - RUN: if en=0, go to STOP. If amp_target≠amp (sampled at tick), go to RAMP.
  - STOP: at each wrap, amp is decremented by RAMP_STEP, saturating at 0. At a wrap where amp_next==0, go to IDLE with idx=0, polarity=0, duty=0. If en=1 before that, go to RAMP from the current amp.
- Simultaneous events:
  - A wrap and a state change on the same tick: the amp step uses the rules of the current state.
  - en and amp_target changes between ticks are ignored until the next tick.
- Reset mid-operation: all registers return to their reset values immediately, with no clock required.

## Timing
- duty, polarity and state change on the same edge where cnt goes PERIOD_TOP→0. They are stable for the entire following period.
- Latency from en rising to the first nonzero duty is at most 2 ticks plus one half-cycle.
  - The first amp step occurs at the first wrap after entering RAMP.
- period_tick is a single-cycle pulse and is registered: it is high while cnt==PERIOD_TOP.
- After rst falls, the first tick occurs PERIOD_TOP clocks after the first rising edge.

## Configuration
- SSPWM_SEQ_MINPULSE_EN defined:
  - A computed duty with 0<duty<MIN_PULSE is forced to 0.
  - A computed duty with duty>PERIOD_TOP-MIN_PULSE is forced to PERIOD_TOP.
- Undefined: duty is the raw scaled value and MIN_PULSE is unused.

## Test plan
- Reset: assert rst=1 between edges → cnt=0, duty=0, polarity=0, period_tick=0 and state=0 immediately, with no clock edge.
- Soft start: en=1, amp_target=255, defaults → state 1 after the first tick. amp rises 16 per wrap (16, 32, … 240, then saturates to 255). state becomes 2 on the 16th wrap, and polarity toggles at each wrap.
- Peak sample: in RUN with amp=255, tick loading idx=32 → duty=(3906*255)>>8=3890. At idx=0, duty=0.
- Soft stop: in RUN, drop en → state 3. amp falls 255→239→…→15→0 at successive wraps, then state 0 with duty=0, polarity=0, idx=0. Reasserting en while amp=127 → state 1 and amp climbs from 127.
- Async reset mid-ramp: assert rst at cnt=1000 in RAMP → all outputs are at reset values before the next edge. After release, the first tick occurs at cnt=3906.
- Macro: with amp=16, tick loading idx=1 (lut[1]=192) → raw duty=12. Required: duty=0 with SSPWM_SEQ_MINPULSE_EN defined, duty=12 without.
